// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the 6-bit-opcode MIPS-subset datapath.
// Steps fetch/decode/execute/memory/write-back and flags illegal opcodes and memory timeouts.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       retire,
    output logic [3:0] state,
    output logic [1:0] halt_cause
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StExecI   = 4'd3,
        StMemAddr = 4'd4,
        StMemRd   = 4'd5,
        StMemWr   = 4'd6,
        StWbR     = 4'd7,
        StWbI     = 4'd8,
        StWbMem   = 4'd9,
        StBranch  = 4'd10,
        StHalt    = 4'd11
    } state_e;

    localparam bit         TimeoutEn   = (MEM_TIMEOUT != 0);
    localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 32'd1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] halt_cause_q, halt_cause_d;
    logic       in_wait;
    logic       timeout;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            wait_cnt_q   <= 8'd0;
            halt_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            halt_cause_q <= halt_cause_d;
        end
    end

    assign in_wait = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // A ready on the last allowed cycle still wins over the timeout.
    assign timeout = TimeoutEn && in_wait && !mem_ready && (wait_cnt_q == TimeoutLast);

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
                else if (timeout) state_d = StHalt;
            end
            StDecode: begin
                if (opcode <= 6'd4) state_d = StExecR;
                else if (opcode <= 6'd9) state_d = StExecI;
                else if (opcode <= 6'd11) state_d = StMemAddr;
                else if (opcode == 6'd12) state_d = StBranch;
                else begin
                    state_d      = StHalt;
                    halt_cause_d = 2'b01;
                end
            end
            StExecR:   state_d = StWbR;
            StExecI:   state_d = StWbI;
            StMemAddr: state_d = (opcode == 6'd10) ? StMemRd : StMemWr;
            StMemRd: begin
                if (mem_ready) state_d = StWbMem;
                else if (timeout) state_d = StHalt;
            end
            StMemWr: begin
                if (mem_ready) state_d = StFetch;
                else if (timeout) state_d = StHalt;
            end
            StWbR, StWbI, StWbMem, StBranch: state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StHalt;
        endcase
        if (timeout) halt_cause_d = 2'b10;
    end

    // Wait counter saturates so a disabled timeout never wraps into a false match.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) wait_cnt_d = 8'd0;
        else if (in_wait && !mem_ready && (wait_cnt_q != 8'hff)) wait_cnt_d = wait_cnt_q + 8'd1;
    end

    // Output decode; ir_we/pc_we/retire are Mealy in FETCH, MEM_WR and BRANCH.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                StDecode: alu_src_b = 2'b11;
                StExecR: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd2;
                end
                StExecI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'd2;
                end
                StMemAddr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    retire    = mem_ready;
                end
                StWbR: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                end
                StWbI: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                StWbMem: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                StBranch: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd1;
                    pc_src    = 1'b1;
                    pc_we     = zero;
                    retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state      = state_q;
    assign halt_cause = halt_cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table, directed corner cases and a randomized
// instruction stream checked against a per-instruction phase-list model.
module tb_multicycle_ctrl;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, iord, ir_we, pc_we, pc_src, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_dst, reg_write, mem_to_reg, retire;
    logic [3:0] state;
    logic [1:0] halt_cause;

    int n_total = 0;
    int n_pass  = 0;
    int ret_cnt = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .retire     (retire),
        .state      (state),
        .halt_cause (halt_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [14:0] ctl();
        return {mem_read, mem_write, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
                reg_dst, reg_write, mem_to_reg, retire};
    endfunction

    // Control word each state must present, straight from the state table.
    function automatic logic [14:0] exp_ctl(input int st, input logic mr, input logic z);
        logic mrd = 0, mwr = 0, ia = 0, irw = 0, pcw = 0, pcs = 0, sa = 0;
        logic rd = 0, rw = 0, mtr = 0, ret = 0;
        logic [1:0] sb = 2'b00, op = 2'b00;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; op = 2'd2; end
            3:  begin sa = 1; sb = 2'b10; op = 2'd2; end
            4:  begin sa = 1; sb = 2'b10; end
            5:  begin mrd = 1; ia = 1; end
            6:  begin mwr = 1; ia = 1; ret = mr; end
            7:  begin rw = 1; rd = 1; ret = 1; end
            8:  begin rw = 1; ret = 1; end
            9:  begin rw = 1; mtr = 1; ret = 1; end
            10: begin sa = 1; op = 2'd1; pcs = 1; pcw = z; ret = 1; end
            default: ;
        endcase
        return {mrd, mwr, ia, irw, pcw, pcs, sa, sb, op, rd, rw, mtr, ret};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_ctl", 32'(ctl()), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        check("reset_cause", 32'(halt_cause), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive inputs, check state and control word, advance to next negedge.
    task automatic step(input string name, input int st, input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        #1;
        check({name, "_state"}, 32'(state), 32'(st));
        check({name, "_ctl"}, 32'(ctl()), 32'(exp_ctl(st, mr, z)));
        ret_cnt += int'(retire);
        @(negedge clk);
    endtask

    typedef struct {
        logic [5:0] opc;
        logic       z;
        int         cycles;
        int         last_st;
        logic [1:0] cause;
    } vec_t;

    initial begin
        vec_t vecs[12];
        int   q[$];
        int   waits, cyc, last, bad;
        bit   found;
        logic mr, z;
        int   opc, ph;

        vecs = '{'{6'd2, 1'b0, 4, 7, 2'b00}, '{6'd0, 1'b1, 4, 7, 2'b00},
                 '{6'd4, 1'b0, 4, 7, 2'b00}, '{6'd5, 1'b0, 4, 8, 2'b00},
                 '{6'd9, 1'b1, 4, 8, 2'b00}, '{6'd10, 1'b0, 5, 9, 2'b00},
                 '{6'd11, 1'b0, 4, 6, 2'b00}, '{6'd12, 1'b1, 3, 10, 2'b00},
                 '{6'd12, 1'b0, 3, 10, 2'b00}, '{6'd13, 1'b0, 2, 11, 2'b01},
                 '{6'd63, 1'b0, 2, 11, 2'b01}, '{6'd7, 1'b0, 4, 8, 2'b00}};

        // Vector table: zero-wait latency, final state and halt cause per opcode
        foreach (vecs[k]) begin
            do_reset();
            opcode    = vecs[k].opc;
            zero      = vecs[k].z;
            mem_ready = 1'b1;
            cyc = 0; last = -1; found = 0;
            for (int i = 0; i < 12 && !found; i++) begin
                #1;
                if (state == 4'd11) begin cyc = i; last = 11; found = 1; end
                else if (retire) begin cyc = i + 1; last = int'(state); found = 1; end
                @(negedge clk);
            end
            check($sformatf("vec%0d_cycles", k), 32'(cyc), 32'(vecs[k].cycles));
            check($sformatf("vec%0d_last", k), 32'(last), 32'(vecs[k].last_st));
            check($sformatf("vec%0d_cause", k), 32'(halt_cause), 32'(vecs[k].cause));
        end

        // R-type: 0,1,2,7,0 with a single retire
        do_reset();
        opcode = 6'd2; ret_cnt = 0;
        step("r_f", 0, 1, 0);
        step("r_d", 1, 1, 0);
        step("r_x", 2, 1, 0);
        #1;
        check("r_wb_regs", 32'({reg_write, reg_dst}), 32'b11);
        step("r_wb", 7, 1, 0);
        step("r_f2", 0, 0, 0);
        check("r_retire_once", 32'(ret_cnt), 32'd1);

        // lw with three FETCH wait cycles: 8 cycles total
        do_reset();
        opcode = 6'd10;
        for (int i = 0; i < 3; i++) step("lw_fwait", 0, 0, 0);
        #1;
        check("lw_irwe_low", 32'(ir_we), 32'd0);
        step("lw_f", 0, 1, 0);
        step("lw_d", 1, 1, 0);
        step("lw_a", 4, 1, 0);
        step("lw_rd", 5, 1, 0);
        #1;
        check("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
        step("lw_wb", 9, 1, 0);
        step("lw_f2", 0, 1, 0);

        // Branch taken and not taken
        for (int t = 1; t >= 0; t--) begin
            do_reset();
            opcode = 6'd12;
            step("br_f", 0, 1, 1'(t));
            step("br_d", 1, 1, 1'(t));
            zero = 1'(t);
            #1;
            check("br_pc_we", 32'(pc_we), 32'(t));
            check("br_pc_src", 32'(pc_src), 32'd1);
            step("br_b", 10, 1, 1'(t));
            step("br_f2", 0, 1, 0);
        end

        // Illegal opcode halts, stays quiet, and reset clears it
        do_reset();
        opcode = 6'd13;
        step("ill_f", 0, 1, 0);
        step("ill_d", 1, 1, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            #1;
            if (ctl() != 15'd0 || state != 4'd11 || halt_cause != 2'b01) bad++;
            @(negedge clk);
        end
        check("ill_halt_held", 32'(bad), 32'd0);
        do_reset();
        #1;
        check("ill_after_state", 32'(state), 32'd0);
        check("ill_after_cause", 32'(halt_cause), 32'd0);

        // sw timeout after 4 MEM_WR cycles, then ready on the 4th completes
        opcode = 6'd11;
        step("to_f", 0, 1, 0);
        step("to_d", 1, 1, 0);
        step("to_a", 4, 1, 0);
        for (int i = 0; i < 4; i++) step("to_wait", 6, 0, 0);
        #1;
        check("to_halt_state", 32'(state), 32'd11);
        check("to_halt_cause", 32'(halt_cause), 32'b10);
        do_reset();
        opcode = 6'd11;
        step("ok_f", 0, 1, 0);
        step("ok_d", 1, 1, 0);
        step("ok_a", 4, 1, 0);
        for (int i = 0; i < 3; i++) step("ok_wait", 6, 0, 0);
        mem_ready = 1'b1;
        #1;
        check("ok_retire", 32'(retire), 32'd1);
        step("ok_wr", 6, 1, 0);
        step("ok_f2", 0, 1, 0);
        check("ok_cause", 32'(halt_cause), 32'd0);

        // Fetch timeout
        do_reset();
        for (int i = 0; i < 4; i++) step("fto_wait", 0, 0, 0);
        #1;
        check("fto_state", 32'(state), 32'd11);
        check("fto_cause", 32'(halt_cause), 32'b10);

        // Asynchronous reset during EXEC_I
        do_reset();
        opcode = 6'd5;
        step("ar_f", 0, 1, 0);
        step("ar_d", 1, 1, 0);
        #1;
        check("ar_in_exec_i", 32'(state), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ctl_zero", 32'(ctl()), 32'd0);
        check("ar_state_zero", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("ar_after", 0, 1, 0);

        // Randomized instruction stream against the phase-list model
        do_reset();
        waits = 0;
        for (int n = 0; n < 400; n++) begin
            if (q.size() == 0) begin
                opc    = int'($urandom_range(0, 12));
                opcode = 6'(opc);
                if (opc <= 4) q = '{0, 1, 2, 7};
                else if (opc <= 9) q = '{0, 1, 3, 8};
                else if (opc == 10) q = '{0, 1, 4, 5, 9};
                else if (opc == 11) q = '{0, 1, 4, 6};
                else q = '{0, 1, 10};
                waits = 0;
            end
            ph = q[0];
            z  = 1'($urandom_range(0, 1));
            if (ph == 0 || ph == 5 || ph == 6)
                mr = (waits >= int'(TO) - 1) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            else
                mr = 1'($urandom_range(0, 1));
            step("rnd", ph, mr, z);
            if ((ph == 0 || ph == 5 || ph == 6) && !mr) waits++;
            else begin
                void'(q.pop_front());
                waits = 0;
            end
        end
        check("rnd_no_halt", 32'(halt_cause), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
